// File: rtl/car_sprite_render_if.sv
// Pixel-stream and register-port bundle for car_sprite_render.
// The master side drives the pixel stream, register writes and LUT data; the slave side is the renderer.
interface car_sprite_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10
);
   logic [10:0]           x;
   logic [10:0]           y;
   logic [DATA_WIDTH-1:0] si_rgb;
   logic                  wr_en;
   logic [1:0]            wr_addr;
   logic [31:0]           wr_data;
   logic [ADDR_WIDTH-1:0] sprite_addr;
   logic [DATA_WIDTH-1:0] pix_f1;
   logic [DATA_WIDTH-1:0] pix_f2;
   logic [DATA_WIDTH-1:0] rgb_out;

   modport master (
      output x, y, si_rgb, wr_en, wr_addr, wr_data, pix_f1, pix_f2,
      input  sprite_addr, rgb_out
   );

   modport slave (
      input  x, y, si_rgb, wr_en, wr_addr, wr_data, pix_f1, pix_f2,
      output sprite_addr, rgb_out
   );
endinterface

// File: rtl/car_sprite_render.sv
// Two-stage car sprite compositor with chroma key and two-frame animation.
// Optional feature macro: CAR_MIRROR_EN (dir=1 mirrors the sprite horizontally).
module car_sprite_render #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10,
   parameter int ANIM_DIV   = 8
) (
   input  logic         clk,
   input  logic         rst,
   car_sprite_if.slave  vid_io
);
   localparam int CNT_W = ($clog2(ANIM_DIV) > 3) ? $clog2(ANIM_DIV) : 3;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(ANIM_DIV - 1);
   localparam logic [DATA_WIDTH-1:0] KEY_RST  = DATA_WIDTH'(12'hF0F);

   logic [10:0]           x0_q, x0_d, y0_q, y0_d;
   logic [10:0]           x0_sh_q, x0_sh_d, y0_sh_q, y0_sh_d;
   logic                  en_q, en_d, moving_q, moving_d, dir_q, dir_d;
   logic [DATA_WIDTH-1:0] key_q, key_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  frame_sel_q, frame_sel_d;
   logic                  at_origin_q;
   logic                  hit_d1_q, frame_sel_d1_q;
   logic [DATA_WIDTH-1:0] si_rgb_d1_q;
   logic [DATA_WIDTH-1:0] rgb_out_q, rgb_out_d;

   logic                  at_origin, frame_start, hit;
   logic [11:0]           x_ext, y_ext, x0_ext, y0_ext;
   logic [10:0]           dx, dy;
   logic [4:0]            col;
   logic [DATA_WIDTH-1:0] pix;

   // Only the first clock at the origin counts, so a stalled (0,0) is one frame start.
   assign at_origin   = (vid_io.x == 11'd0) && (vid_io.y == 11'd0);
   assign frame_start = at_origin && !at_origin_q;

   // Box bounds are compared at 12 bits so x0+32 never wraps near the raster edge.
   assign x_ext  = {1'b0, vid_io.x};
   assign y_ext  = {1'b0, vid_io.y};
   assign x0_ext = {1'b0, x0_q};
   assign y0_ext = {1'b0, y0_q};
   assign hit    = en_q
                && (x_ext >= x0_ext) && (x_ext < x0_ext + 12'd32)
                && (y_ext >= y0_ext) && (y_ext < y0_ext + 12'd32);

   assign dx = vid_io.x - x0_q;
   assign dy = vid_io.y - y0_q;

`ifdef CAR_MIRROR_EN
   assign col = dir_q ? (5'd31 - dx[4:0]) : dx[4:0];
`else
   assign col = dx[4:0];
`endif

   assign vid_io.sprite_addr = ADDR_WIDTH'({dy[4:0], col});

   logic unused_bits;
   assign unused_bits = ^{dx[10:5], dy[10:5], dir_q, vid_io.wr_data};

   always_comb begin
      x0_d        = x0_q;
      y0_d        = y0_q;
      x0_sh_d     = x0_sh_q;
      y0_sh_d     = y0_sh_q;
      en_d        = en_q;
      moving_d    = moving_q;
      dir_d       = dir_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      frame_sel_d = frame_sel_q;

      // Animation uses the registered moving bit, so a same-cycle ctrl write lands afterwards.
      if (frame_start) begin
         x0_d = x0_sh_q;
         y0_d = y0_sh_q;
         if (moving_q) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               frame_sel_d = ~frame_sel_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      if (vid_io.wr_en) begin
         case (vid_io.wr_addr)
            2'd0: x0_sh_d = vid_io.wr_data[10:0];
            2'd1: y0_sh_d = vid_io.wr_data[10:0];
            2'd2: {dir_d, moving_d, en_d} = vid_io.wr_data[2:0];
            default: key_d = vid_io.wr_data[DATA_WIDTH-1:0];
         endcase
      end
   end

   // LUT data for the stage-1 pixel arrives during stage 2.
   assign pix       = frame_sel_d1_q ? vid_io.pix_f2 : vid_io.pix_f1;
   assign rgb_out_d = (hit_d1_q && (pix != key_q)) ? pix : si_rgb_d1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0_q           <= '0;
         y0_q           <= '0;
         x0_sh_q        <= '0;
         y0_sh_q        <= '0;
         en_q           <= 1'b0;
         moving_q       <= 1'b0;
         dir_q          <= 1'b0;
         key_q          <= KEY_RST;
         cnt_q          <= '0;
         frame_sel_q    <= 1'b0;
         at_origin_q    <= 1'b0;
         hit_d1_q       <= 1'b0;
         frame_sel_d1_q <= 1'b0;
         si_rgb_d1_q    <= '0;
         rgb_out_q      <= '0;
      end else begin
         x0_q           <= x0_d;
         y0_q           <= y0_d;
         x0_sh_q        <= x0_sh_d;
         y0_sh_q        <= y0_sh_d;
         en_q           <= en_d;
         moving_q       <= moving_d;
         dir_q          <= dir_d;
         key_q          <= key_d;
         cnt_q          <= cnt_d;
         frame_sel_q    <= frame_sel_d;
         at_origin_q    <= at_origin;
         hit_d1_q       <= hit;
         frame_sel_d1_q <= frame_sel_q;
         si_rgb_d1_q    <= vid_io.si_rgb;
         rgb_out_q      <= rgb_out_d;
      end
   end

   assign vid_io.rgb_out = rgb_out_q;
endmodule

// File: tb/tb_car_sprite_render.sv
// Self-checking bench for car_sprite_render: table vectors plus hand sequences, scoreboard on rgb_out.
module tb_car_sprite_render;
   localparam int DW = 12;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   car_sprite_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) vif ();

   car_sprite_render #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ANIM_DIV(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .vid_io (vif)
   );

   // Registered-read LUT model for both car frames.
   logic [DW-1:0] lut1 [1024];
   logic [DW-1:0] lut2 [1024];
   always @(posedge clk) begin
      vif.pix_f1 <= lut1[vif.sprite_addr];
      vif.pix_f2 <= lut2[vif.sprite_addr];
   end

   typedef struct {
      int unsigned   due;
      logic [DW-1:0] exp;
      string         tag;
   } sb_t;
   sb_t sb[$];
   sb_t mon_e;

   typedef struct {
      logic [10:0]   x;
      logic [10:0]   y;
      logic [DW-1:0] si;
      bit            ca;
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t tbl[8];

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   // Output monitor: one cycle counter, compare every entry that falls due.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.due != cyc || vif.rgb_out !== mon_e.exp) begin
               errors++;
               $display("FAIL %s: rgb_out=%h expected %h (cycle %0d due %0d)",
                        mon_e.tag, vif.rgb_out, mon_e.exp, cyc, mon_e.due);
            end else begin
               $display("ok   %s: rgb_out=%h", mon_e.tag, vif.rgb_out);
            end
         end
      end
   end

   task automatic px(input logic [10:0] x, input logic [10:0] y, input logic [DW-1:0] si,
                     input bit chk, input logic [DW-1:0] exp, input string tag,
                     input bit we = 1'b0, input logic [1:0] wa = 2'd0, input logic [31:0] wd = 32'd0);
      @(negedge clk);
      vif.x       = x;
      vif.y       = y;
      vif.si_rgb  = si;
      vif.wr_en   = we;
      vif.wr_addr = wa;
      vif.wr_data = wd;
      if (chk) sb.push_back('{due: cyc + 2, exp: exp, tag: tag});
   endtask

   task automatic chk_addr(input logic [AW-1:0] e, input string tag);
      #1;
      checks++;
      if (vif.sprite_addr !== e) begin
         errors++;
         $display("FAIL %s: sprite_addr=%0d expected %0d", tag, vif.sprite_addr, e);
      end else begin
         $display("ok   %s: sprite_addr=%0d", tag, vif.sprite_addr);
      end
   endtask

   task automatic chk_rgb_now(input logic [DW-1:0] e, input string tag);
      checks++;
      if (vif.rgb_out !== e) begin
         errors++;
         $display("FAIL %s: rgb_out=%h expected %h", tag, vif.rgb_out, e);
      end else begin
         $display("ok   %s: rgb_out=%h", tag, vif.rgb_out);
      end
   endtask

   task automatic idle();
      px(11'd2000, 11'd2000, 12'h321, 1'b1, 12'h321, "idle");
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      px(11'd2000, 11'd2000, 12'h321, 1'b1, 12'h321, "wr", 1'b1, a, d);
   endtask

   task automatic frame();
      px(11'd0, 11'd0, 12'h000, 1'b0, 12'h000, "fs");
   endtask

   task automatic drain();
      repeat (3) idle();
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b);
      for (int i = 0; i < 1024; i++) begin
         lut1[i] = a;
         lut2[i] = b;
      end
   endtask

   initial begin
      tbl[0] = '{x: 11'd100, y: 11'd50, si: 12'h111, ca: 1'b1, addr: 10'd0,    exp: 12'hABC};
      tbl[1] = '{x: 11'd131, y: 11'd81, si: 12'h222, ca: 1'b1, addr: 10'd1023, exp: 12'hABC};
      tbl[2] = '{x: 11'd132, y: 11'd81, si: 12'h333, ca: 1'b0, addr: 10'd0,    exp: 12'h333};
      tbl[3] = '{x: 11'd99,  y: 11'd50, si: 12'h444, ca: 1'b0, addr: 10'd0,    exp: 12'h444};
      tbl[4] = '{x: 11'd115, y: 11'd66, si: 12'h555, ca: 1'b1, addr: 10'd527,  exp: 12'hABC};
      tbl[5] = '{x: 11'd131, y: 11'd82, si: 12'h666, ca: 1'b0, addr: 10'd0,    exp: 12'h666};
      tbl[6] = '{x: 11'd100, y: 11'd49, si: 12'h777, ca: 1'b0, addr: 10'd0,    exp: 12'h777};
      tbl[7] = '{x: 11'd116, y: 11'd65, si: 12'h888, ca: 1'b1, addr: 10'd496,  exp: 12'hABC};

      vif.x = 11'd2000; vif.y = 11'd2000; vif.si_rgb = '0;
      vif.wr_en = 1'b0; vif.wr_addr = '0; vif.wr_data = '0;
      fill(12'h000, 12'h000);

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk_rgb_now(12'h000, "reset_rgb");
      @(negedge clk);
      rst = 1'b0;

      // Pass-through with sprite disabled
      for (int i = 0; i < 4; i++)
         px(11'($urandom_range(1, 2047)), 11'($urandom_range(1, 2047)), 12'h123, 1'b1, 12'h123, "passthru");

      // Place the car at (100,50) and enable it
      wr(2'd0, 32'd100);
      wr(2'd1, 32'd50);
      wr(2'd2, 32'd1);
      drain();
      fill(12'hABC, 12'hDEF);
      frame();
      for (int i = 0; i < 8; i++) begin
         px(tbl[i].x, tbl[i].y, tbl[i].si, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
         if (tbl[i].ca) chk_addr(tbl[i].addr, $sformatf("tbl%0d_addr", i));
      end

      // Chroma key: default key hides F0F, zero key shows it
      drain();
      fill(12'hF0F, 12'hF0F);
      px(11'd110, 11'd60, 12'h246, 1'b1, 12'h246, "key_default");
      wr(2'd3, 32'h000);
      px(11'd110, 11'd60, 12'h246, 1'b1, 12'hF0F, "key_zero");
      wr(2'd3, 32'hF0F);
      drain();
      fill(12'hABC, 12'hDEF);

      // Direction bit
      wr(2'd2, 32'd5);
      px(11'd100, 11'd50, 12'h111, 1'b1, 12'hABC, "dir_hit");
`ifdef CAR_MIRROR_EN
      chk_addr(10'd31, "dir_addr0");
      px(11'd101, 11'd50, 12'h111, 1'b1, 12'hABC, "dir_hit1");
      chk_addr(10'd30, "dir_addr1");
`else
      chk_addr(10'd0, "dir_addr0");
      px(11'd101, 11'd50, 12'h111, 1'b1, 12'hABC, "dir_hit1");
      chk_addr(10'd1, "dir_addr1");
`endif
      wr(2'd2, 32'd1);

      // Shadowed x0: takes effect only at the next frame start
      wr(2'd0, 32'd200);
      px(11'd110, 11'd60, 12'h111, 1'b1, 12'hABC, "shadow_old_hit");
      px(11'd210, 11'd60, 12'h222, 1'b1, 12'h222, "shadow_new_miss");
      frame();
      px(11'd110, 11'd60, 12'h111, 1'b1, 12'h111, "shadow_old_miss");
      px(11'd210, 11'd60, 12'h222, 1'b1, 12'hABC, "shadow_new_hit");

      // Animation: toggles at the 8th and 16th frame start
      wr(2'd2, 32'd3);
      for (int f = 1; f <= 16; f++) begin
         frame();
         px(11'd210, 11'd60, 12'h000, 1'b1, (f >= 8 && f < 16) ? 12'hDEF : 12'hABC, $sformatf("anim_f%0d", f));
      end
      for (int f = 1; f <= 3; f++) begin
         frame();
         px(11'd210, 11'd60, 12'h000, 1'b1, 12'hABC, $sformatf("anim_pre_stop%0d", f));
      end
      wr(2'd2, 32'd1);
      for (int f = 1; f <= 20; f++) begin
         frame();
         px(11'd210, 11'd60, 12'h000, 1'b1, 12'hABC, $sformatf("anim_hold%0d", f));
      end

      // ctrl write coinciding with frame start: that frame must not count
      px(11'd0, 11'd0, 12'h000, 1'b0, 12'h000, "fs_wr", 1'b1, 2'd2, 32'd3);
      px(11'd210, 11'd60, 12'h000, 1'b1, 12'hABC, "coinc_f0");
      for (int f = 1; f <= 5; f++) begin
         frame();
         px(11'd210, 11'd60, 12'h000, 1'b1, (f == 5) ? 12'hDEF : 12'hABC, $sformatf("coinc_f%0d", f));
      end
      wr(2'd2, 32'd1);

      // Asynchronous reset mid-line
      drain();
      settle();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_rgb_now(12'h000, "async_rst");
      sb.delete();
      repeat (2) @(negedge clk);
      chk_rgb_now(12'h000, "rst_hold");
      rst = 1'b0;

      // Post-reset tracking, default key, frame_sel cleared
      for (int i = 0; i < 3; i++)
         px(11'($urandom_range(40, 2047)), 11'($urandom_range(40, 2047)), 12'(12'h0A0 + i), 1'b1, 12'(12'h0A0 + i), "post_rst");
      wr(2'd2, 32'd1);
      drain();
      fill(12'hF0F, 12'hF0F);
      px(11'd5, 11'd5, 12'h0AA, 1'b1, 12'h0AA, "post_rst_key");
      drain();
      fill(12'hABC, 12'hDEF);
      px(11'd5, 11'd5, 12'h0AA, 1'b1, 12'hABC, "post_rst_hit");

      drain();
      settle();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/car_sprite_render.md
CAR_SPRITE_RENDER -- requirements
Module: car_sprite_render

Interface
REQ-001 Parameter DATA_WIDTH, default 12, SHALL set the RGB color depth.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the sprite LUT address width; the sprite is 32x32 pixels.
REQ-003 Parameter ANIM_DIV, default 8, SHALL set the number of video frames per animation frame toggle.
REQ-004 clk  in  1  SHALL be the single clock; every register is clocked on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 x, y  in  11 each  SHALL carry the current pixel coordinates.
REQ-007 si_rgb  in  DATA_WIDTH  SHALL carry the background pixel from the upstream stage.
REQ-008 wr_en  in  1 / wr_addr  in  2 / wr_data  in  32  SHALL form the register write port.
REQ-009 sprite_addr  out  ADDR_WIDTH  SHALL drive addr_r of both car frame LUTs; the LUTs have 1-cycle registered reads.
REQ-010 pix_f1, pix_f2  in  DATA_WIDTH each  SHALL carry frame-1 and frame-2 LUT read data.
REQ-011 rgb_out  out  DATA_WIDTH  SHALL carry the composited pixel.

Function
REQ-012 Register map SHALL be: 0 x0[10:0]; 1 y0[10:0]; 2 ctrl {dir bit2, moving bit1, enable bit0}; 3 chroma key[11:0].
REQ-013 Writes to registers 0 and 1 SHALL go to shadow registers; the shadows SHALL copy to active x0/y0 on the first clock where x==0 and y==0 (frame_start).
REQ-014 Writes to registers 2 and 3 SHALL take effect on the next clock.
REQ-015 hit SHALL be enable && x>=x0 && x<x0+32 && y>=y0 && y<y0+32, with the sums computed at 12 bits, so there is no wrap at x0>2015.
REQ-016 sprite_addr SHALL be combinational: {(y-y0)[4:0], col[4:0]}, where col=(x-x0)[4:0].
REQ-017 Pipeline stage 1 SHALL register hit, si_rgb and frame_sel; the LUT data is valid in the same cycle.
REQ-018 Stage 2 SHALL register rgb_out as: pix = frame_sel ? pix_f2 : pix_f1; rgb_out = (hit_d1 && pix!=key) ? pix : si_rgb_d1.
REQ-019 Latency from x/y/si_rgb to rgb_out SHALL be exactly 2 clocks; throughput SHALL be one pixel per clock.
REQ-020 The animation counter (3 bits minimum) SHALL increment on frame_start while moving=1.
REQ-021 At frame_start with counter==ANIM_DIV-1, the counter SHALL clear to 0 and frame_sel SHALL toggle.
REQ-022 While moving=0, the counter and frame_sel SHALL hold.
REQ-023 When a register-2 write and frame_start coincide, the counter SHALL use the pre-write moving value.

Reset
REQ-024 Reset SHALL clear x0, y0, their shadows, ctrl, counter, frame_sel, the pipeline registers and rgb_out to 0, and SHALL set key to 12'hF0F.
REQ-025 Reset asserted mid-line SHALL force rgb_out=0 immediately, with no clock needed.
REQ-026 After reset release, rgb_out SHALL track si_rgb with 2-clock latency.

Configuration
REQ-027 With CAR_MIRROR_EN defined, col SHALL be 31-(x-x0)[4:0] when dir=1, giving a left-facing car.
REQ-028 Without CAR_MIRROR_EN, dir SHALL be ignored and col=(x-x0)[4:0] always.

Verification
REQ-029 Bench SHALL check: reset, si_rgb=12'h123 at any x/y -> rgb_out=12'h123 two clocks later.
REQ-030 Bench SHALL check: x0=100, y0=50, enable=1, frame_start, pix_f1=12'hABC, x=100, y=50 -> sprite_addr=0, rgb_out=12'hABC after 2 clocks; x=131, y=81 -> addr=1023; x=132 -> si_rgb passes.
REQ-031 Bench SHALL check: pix_f1=12'hF0F inside the box -> rgb_out=si_rgb; after a key write of 12'h000 -> rgb_out=12'hF0F.
REQ-032 Bench SHALL check: moving=1, ANIM_DIV=8 -> frame_sel toggles on the 8th and 16th frame_start; clearing moving after 3 frames -> no toggle over 20 frames.
REQ-033 Bench SHALL check: writing x0=200 mid-frame -> hit region unchanged until the next x=0,y=0, then moves.
REQ-034 Bench SHALL check, with CAR_MIRROR_EN defined: dir=1, x=x0, y=y0 -> sprite_addr=31; without the macro -> 0.
